// File: rtl/csr_switches.sv
// CSR-mapped switch input: two-flop sync and per-bit debounce, rising-edge
// capture with a maskable level interrupt, plus STATE/CAPTURE/MASK registers.
module csr_switches #(
  parameter logic [11:0] BASE_ADDR       = 12'h7c2,
  parameter int          WIDTH           = 18,
  parameter int          DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             read,
  input  logic [1:0]       modify,
  input  logic [31:0]      wdata,
  input  logic [11:0]      addr,
  output logic [31:0]      rdata,
  output logic             valid,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] state,
  output logic             irq,
  output logic             AVOID_WARNING
);

  localparam int              CW         = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_TC     = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [11:0]     ADDR_STATE = BASE_ADDR;
  localparam logic [11:0]     ADDR_CAP   = BASE_ADDR + 12'd1;
  localparam logic [11:0]     ADDR_MASK  = BASE_ADDR + 12'd2;

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] deb_q, deb_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] wd;
  logic [31:0]      rdata_q, rdata_d;
  logic             valid_q, valid_d;
  logic             irq_q, irq_d;

  function automatic logic [WIDTH-1:0] apply_mod(input logic [1:0] m,
                                                 input logic [WIDTH-1:0] cur,
                                                 input logic [WIDTH-1:0] val);
    case (m)
      2'b01:   return val;
      2'b10:   return cur | val;
      2'b11:   return cur & ~val;
      default: return cur;
    endcase
  endfunction

  assign wd = wdata[WIDTH-1:0];

  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_TC) deb_d[i] = s2_q[i];
        else                    cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  assign rise = deb_d & ~deb_q;

  // Reads return the pre-modify value; a hardware rising edge overrides a clear.
  always_comb begin
    cap_d   = cap_q;
    mask_d  = mask_q;
    rdata_d = '0;
    valid_d = 1'b0;
    case (addr)
      ADDR_STATE: begin
        valid_d = 1'b1;
        rdata_d = 32'(deb_q);
      end
      ADDR_CAP: begin
        valid_d = 1'b1;
        rdata_d = 32'(cap_q);
        cap_d   = apply_mod(modify, cap_q, wd);
      end
      ADDR_MASK: begin
        valid_d = 1'b1;
        rdata_d = 32'(mask_q);
        mask_d  = apply_mod(modify, mask_q, wd);
      end
      default: ;
    endcase
    cap_d = cap_d | rise;
    irq_d = |(cap_q & mask_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      deb_q   <= '0;
      cap_q   <= '0;
      mask_q  <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      irq_q   <= 1'b0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      s1_q    <= sw;
      s2_q    <= s1_q;
      deb_q   <= deb_d;
      cap_q   <= cap_d;
      mask_q  <= mask_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      irq_q   <= irq_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign rdata = rdata_q;
  assign valid = valid_q;
  assign state = deb_q;
  assign irq   = irq_q;

  generate
    if (WIDTH < 32) begin : g_sink_hi
      assign AVOID_WARNING = read | (|wdata[31:WIDTH]);
    end else begin : g_sink_full
      assign AVOID_WARNING = read;
    end
  endgenerate

endmodule

// File: tb/tb_csr_switches.sv
// Bench for csr_switches: directed scenarios followed by random traffic, all
// checked every cycle against a window-based behavioural model.
module tb_csr_switches;
  localparam int          W    = 4;
  localparam int          D    = 4;
  localparam logic [11:0] BASE = 12'h7c2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          read = 1'b0;
  logic [1:0]    modify = 2'b00;
  logic [31:0]   wdata = '0;
  logic [11:0]   addr = '0;
  logic [31:0]   rdata;
  logic          valid;
  logic [W-1:0]  sw = '0;
  logic [W-1:0]  state;
  logic          irq;
  logic          avoid;

  always #5 clk = ~clk;

  csr_switches #(.BASE_ADDR(BASE), .WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .read(read), .modify(modify), .wdata(wdata),
    .addr(addr), .rdata(rdata), .valid(valid), .sw(sw), .state(state),
    .irq(irq), .AVOID_WARNING(avoid)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: deb flips once the last D synchronised samples all disagree with it
  // and all D were taken after its previous change.
  logic [W-1:0] m_s1 = '0, m_s2 = '0, m_deb = '0, m_cap = '0, m_mask = '0;
  logic [31:0]  m_rdata = '0;
  logic         m_valid = 1'b0, m_irq = 1'b0;
  logic [W-1:0] m_hist[$];
  int           m_since[W];

  function automatic logic [W-1:0] mod_apply(input logic [1:0] m, input logic [W-1:0] cur,
                                             input logic [W-1:0] v);
    case (m)
      2'd1:    return v;
      2'd2:    return cur | v;
      2'd3:    return cur & ~v;
      default: return cur;
    endcase
  endfunction

  task automatic model_edge();
    logic [W-1:0] nd, rise, capm, maskm;
    logic [11:0]  off;
    bit           ok;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0; m_cap = '0; m_mask = '0;
      m_rdata = '0; m_valid = 1'b0; m_irq = 1'b0;
      m_hist.delete();
      for (int b = 0; b < W; b++) m_since[b] = 0;
      return;
    end
    m_hist.push_back(m_s2);
    if (m_hist.size() > D) void'(m_hist.pop_front());
    nd = m_deb;
    for (int b = 0; b < W; b++) begin
      m_since[b]++;
      if (m_since[b] >= D) begin
        ok = 1'b1;
        foreach (m_hist[j]) if (m_hist[j][b] == m_deb[b]) ok = 1'b0;
        if (ok) begin
          nd[b] = ~m_deb[b];
          m_since[b] = 0;
        end
      end
    end
    rise    = nd & ~m_deb;
    m_irq   = |(m_cap & m_mask);
    off     = addr - BASE;
    capm    = m_cap;
    maskm   = m_mask;
    m_valid = 1'b0;
    m_rdata = '0;
    if (off == 12'd0) begin
      m_valid = 1'b1; m_rdata = {28'b0, m_deb};
    end else if (off == 12'd1) begin
      m_valid = 1'b1; m_rdata = {28'b0, m_cap};
      capm = mod_apply(modify, m_cap, wdata[W-1:0]);
    end else if (off == 12'd2) begin
      m_valid = 1'b1; m_rdata = {28'b0, m_mask};
      maskm = mod_apply(modify, m_mask, wdata[W-1:0]);
    end
    m_cap  = capm | rise;
    m_mask = maskm;
    m_s2   = m_s1;
    m_s1   = sw;
    m_deb  = nd;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [W-1:0] s, input logic [11:0] a = 12'h000,
                      input logic [1:0] m = 2'd0, input logic [31:0] wd = '0,
                      input logic r = 1'b0);
    sw = s; addr = a; modify = m; wdata = wd; rst = r;
    read = 1'($urandom_range(0, 1));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("model_state", 32'(state), 32'(m_deb));
    check("model_irq",   32'(irq),   32'(m_irq));
    check("model_valid", 32'(valid), 32'(m_valid));
    check("model_rdata", rdata,      m_rdata);
    check("avoid_warning", 32'(avoid), 32'(read | (|wdata[31:W])));
  endtask

  initial begin
    int hold;
    logic [W-1:0] rs;
    logic [11:0]  ra;

    // reset
    step(4'b0000, 12'h000, 2'd0, 32'h0, 1'b1);
    check("rst_state", 32'(state), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_irq",   32'(irq),   32'h0);

    // debounce latency: deb changes on the sixth edge with the new input
    for (int i = 0; i < 5; i++) begin
      step(4'b0001);
      check("t1_state_early", 32'(state), 32'h0);
    end
    step(4'b0001);
    check("t1_state_set", 32'(state), 32'h1);
    step(4'b0001, 12'h7c3);
    check("t1_cap_valid", 32'(valid), 32'h1);
    check("t1_cap_rdata", rdata, 32'h1);
    step(4'b0001, 12'h000);
    check("t1_nohit_valid", 32'(valid), 32'h0);
    check("t1_nohit_rdata", rdata, 32'h0);

    // glitch rejection on bit 1
    for (int rep = 0; rep < 5; rep++) begin
      for (int i = 0; i < 3; i++) begin
        step(4'b0011);
        check("t2_state1_hi", 32'(state[1]), 32'h0);
      end
      for (int i = 0; i < 3; i++) begin
        step(4'b0001);
        check("t2_state1_lo", 32'(state[1]), 32'h0);
      end
    end
    step(4'b0001, 12'h7c3);
    check("t2_cap", rdata, 32'h1);

    // clear vs. rising edge race on bit 0
    for (int i = 0; i < 6; i++) step(4'b0000);
    check("t4_fall", 32'(state), 32'h0);
    for (int i = 0; i < 5; i++) begin
      step(4'b0001);
      check("t4_state_early", 32'(state), 32'h0);
    end
    step(4'b0001, 12'h7c3, 2'd3, 32'h1);
    check("t4_race_rdata", rdata, 32'h1);
    check("t4_race_state", 32'(state), 32'h1);
    step(4'b0001, 12'h7c3);
    check("t4_edge_wins", rdata, 32'h1);
    step(4'b0001, 12'h7c3, 2'd3, 32'h1);
    step(4'b0001, 12'h7c3);
    check("t4_cleared", rdata, 32'h0);

    // interrupt
    step(4'b0001, 12'h7c4, 2'd1, 32'h4);
    for (int i = 0; i < 6; i++) step(4'b0101);
    check("t5_irq_lag", 32'(irq), 32'h0);
    step(4'b0101);
    check("t5_irq_set", 32'(irq), 32'h1);
    step(4'b0101, 12'h7c3, 2'd3, 32'h4);
    check("t5_irq_hold", 32'(irq), 32'h1);
    step(4'b0101);
    check("t5_irq_clr", 32'(irq), 32'h0);
    for (int i = 0; i < 7; i++) begin
      step(4'b1101);
      check("t5_unmasked", 32'(irq), 32'h0);
    end
    step(4'b1101, 12'h7c3);
    check("t5_cap", rdata, 32'h8);

    // reset mid-debounce
    step(4'b1101, 12'h7c4, 2'd1, 32'hf);
    step(4'b1101, 12'h7c3, 2'd1, 32'ha);
    for (int i = 0; i < 4; i++) step(4'b1100);
    check("t6_irq_before", 32'(irq), 32'h1);
    step(4'b0001, 12'h7c3, 2'd0, 32'h0, 1'b1);
    check("t6_state", 32'(state), 32'h0);
    check("t6_irq",   32'(irq),   32'h0);
    check("t6_valid", 32'(valid), 32'h0);
    step(4'b0001, 12'h7c3);
    check("t6_cap", rdata, 32'h0);
    step(4'b0001, 12'h7c4);
    check("t6_mask", rdata, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(4'b0001);
      check("t6_state_early", 32'(state), 32'h0);
    end
    step(4'b0001);
    check("t6_state_set", 32'(state), 32'h1);

    // randomized traffic
    hold = 0;
    rs = '0;
    for (int n = 0; n < 800; n++) begin
      if (hold == 0) begin
        rs = W'($urandom);
        hold = $urandom_range(1, 9);
      end
      hold--;
      case ($urandom_range(0, 5))
        0, 1, 2: ra = BASE + 12'($urandom_range(0, 2));
        3:       ra = BASE + 12'd3;
        4:       ra = 12'($urandom);
        default: ra = 12'h000;
      endcase
      step(rs, ra, 2'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 199) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/csr_switches.md
Name: csr_switches

Overview:
- CSR-mapped input peripheral: the read-side counterpart to the LED output CSR.
- Samples the board slide switches/keys (DE2-115: SW[17:0]) and synchronises and debounces each bit.
- Latches rising edges and raises a maskable level interrupt.
- Sits on the pipeline's CSR bus next to the counter, UART and LED CSRs; rdata/valid are OR-combined into the pipeline's csr_rdata/csr_valid.

Parameters:
- BASE_ADDR, 12'h7c2: CSR address of STATE; CAPTURE at BASE_ADDR+1, MASK at BASE_ADDR+2.
- WIDTH, 18: number of input bits, 1..32.
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required before the debounced value changes. Minimum 1; 50000 gives 1 ms at 50 MHz.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- read  in  1  CSR read strobe (unused, tied into AVOID_WARNING)
- modify  in  2  00 none, 01 write, 10 set bits, 11 clear bits
- wdata  in  32  CSR write data
- addr  in  12  CSR address
- rdata  out  32  registered read data, 0 when not addressed
- valid  out  1  registered, 1 the cycle after an addr hit
- sw  in  WIDTH  raw asynchronous switch inputs
- state  out  WIDTH  debounced switch value
- irq  out  1  registered, |(CAPTURE & MASK)
- AVOID_WARNING  out  1  read | |wdata[31:WIDTH] (lint sink)

Behaviour:
- Reset (rst high at an edge) clears the following to 0 at that edge, regardless of any concurrent CSR access:
  - sync flops, debounce counters, debounced state, CAPTURE, MASK;
  - rdata, valid, irq.
- Synchroniser: two flops per bit (sw -> s1 -> s2). No reset-time assumption about sw.
- Debounce, per bit with counter cnt of width clog2(DEBOUNCE_CYCLES) (min 1), evaluated each edge:
  - s2 == deb: cnt <= 0.
  - Otherwise, if cnt == DEBOUNCE_CYCLES-1: deb <= s2, cnt <= 0.
  - Otherwise: cnt <= cnt+1.
  - Any glitch back to deb before terminal count restarts the count.
  - Latency: sw changed and held before edge k -> deb updates at edge k+1+DEBOUNCE_CYCLES.
- Edge capture:
  - CAPTURE[i] is set at the same edge that deb[i] goes 0->1.
  - Falling edges are not captured.
  - A switch held high through reset therefore produces a capture after debounce.
- CSR access (no handshake, single cycle):
  - Decode addr at each edge; on a hit, valid <= 1 and rdata <= the zero-extended pre-modify value of the addressed register.
  - No hit: valid <= 0, rdata <= 0.
  - Modify is applied at the same edge as the read capture.
- STATE (BASE_ADDR): read-only; modify ignored, valid still 1.
- CAPTURE (BASE_ADDR+1):
  - 01 write replaces, 10 ORs, 11 clears (AND NOT) with wdata[WIDTH-1:0].
  - Simultaneous new rising edge on bit i and a clear/write-0 of bit i: the edge wins, bit i = 1.
- MASK (BASE_ADDR+2): 01/10/11 as for CAPTURE; no hardware set source.
- irq: irq <= |(CAPTURE & MASK) computed from register values before the edge, so irq lags a CAPTURE/MASK change by one cycle.
- Other addresses, including BASE_ADDR+3: no response.
- Widths: WIDTH < 32 -> rdata[31:WIDTH] = 0; wdata[31:WIDTH] is ignored.
- Reset mid-debounce: count is lost; deb = 0 after reset, and the re-debounce starts from the current s2 once the sync flops refill.

Test Plan (WIDTH=4, DEBOUNCE_CYCLES=4, BASE_ADDR=12'h7c2):
1. Debounce latency: rst 1 cycle; sw=4'b0001 set before edge 0 and held -> state=4'b0001 after edge 5, not before; CAPTURE=4'b0001 at the same edge.
2. Glitch rejection: sw[1] high for 3 cycles then low, repeated 5 times -> state[1] stays 0 and CAPTURE[1] stays 0 throughout.
3. CSR read: with CAPTURE=4'b0001, addr=12'h7c3, modify=00 for one cycle -> next cycle valid=1, rdata=32'h1; following cycle with addr=12'h000 -> valid=0, rdata=0.
4. Clear vs. edge race:
   - Setup: CAPTURE=4'b0001; arrange deb[0] 1->0 earlier; time deb[0] to rise again on the same edge as addr=12'h7c3, modify=11, wdata=1.
   - Required: rdata=1, CAPTURE[0]=1 after that edge.
   - Repeat with no edge -> CAPTURE[0]=0.
5. IRQ:
   - MASK written 4'b0100 via 01; capture rising on sw[2] -> irq=1 one cycle after CAPTURE[2] sets.
   - Clear CAPTURE[2] via 11 -> irq=0 one cycle later.
   - Rising on sw[3] (unmasked) -> irq stays 0.
6. Reset mid-operation: rst asserted while cnt[0]=2 and CAPTURE=4'b1010, MASK=4'b1111 -> next cycle state=0, CAPTURE=0, MASK=0, irq=0, valid=0; sw held 1 -> state[0]=1 six cycles after rst deasserts.
